uart_mem_arbiter: RTL and testbench
===================================

Name: uart_mem_arbiter

Overview:
- Two-requester arbiter and burst sequencer in front of the 1024x32 single-port on-chip UART memory (byte-enabled, address registered, q valid one cycle after the address is clocked).
- Requester 0 is the UART RX/TX data mover; requester 1 is the DDS/CPU side.
- Grants one requester at a time, round-robin, holding the grant for a whole burst.
- Expands read bursts into per-word memory accesses and returns readdatavalid to the owning requester.

Parameters:
ADDR_W, 10, word address width (memory depth 2**ADDR_W)
DATA_W, 32, data width
BE_W, 4, byteenable width (DATA_W/8)
BURST_W, 5, burstcount width; legal bursts are 1..16 words

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
m0_address  in  ADDR_W  requester 0 start word address
m0_read  in  1  requester 0 read request
m0_write  in  1  requester 0 write request (one beat per cycle)
m0_byteenable  in  BE_W  requester 0 byte lanes
m0_writedata  in  DATA_W  requester 0 write data
m0_burstcount  in  BURST_W  requester 0 burst length, sampled on the first accepted beat
m0_waitrequest  out  1  requester 0 stall
m0_readdata  out  DATA_W  requester 0 read data
m0_readdatavalid  out  1  requester 0 read data strobe
m1_*  same set as m0_*, for requester 1
mem_address  out  ADDR_W  to memory address
mem_byteenable  out  BE_W  to memory byteenable
mem_chipselect  out  1  to memory chipselect
mem_write  out  1  to memory write
mem_writedata  out  DATA_W  to memory writedata
mem_clken  out  1  memory clock enable, tied high
mem_readdata  in  DATA_W  from memory readdata

Behaviour:
- Reset (async assert, sync release): state=IDLE, rr_last=1 (requester 0 wins the first tie), beat counter=0, all readdatavalid=0, both waitrequest=1, mem_chipselect=0, mem_write=0.
- FSM states:
  - IDLE: no owner.
  - WR_BURST: owner streams write beats.
  - RD_BURST: arbiter issues reads.
- IDLE:
  - Requests are read|write. A single requester wins outright.
  - If both request, the winner is the one not equal to rr_last.
  - The winner's first beat is accepted the same cycle (its waitrequest=0); the loser's waitrequest stays 1.
  - Latch owner, set rr_last=owner, set beats=burstcount (0 is treated as 1).
  - Write: drive the memory from the owner's address/be/data with write=1. If beats=1, stay IDLE; else go to WR_BURST with addr+1 and remaining=beats-1.
  - Read: issue the first address and accept the command. If beats=1, stay IDLE; else go to RD_BURST with remaining=beats-1.
- WR_BURST:
  - Owner waitrequest=0 only while m_write=1; each beat writes the internal incrementing address (the requester's address is ignored after the first beat). remaining is decremented.
  - Owner idle cycles (write=0): chipselect=0, stay in WR_BURST.
  - After the last beat, return to IDLE. The other requester's waitrequest=1 throughout.
- RD_BURST: the owner's waitrequest=1 (no new command). The arbiter issues consecutive addresses every cycle until remaining=0, then returns to IDLE.
- Read return:
  - Fixed latency 1: mem_readdata is captured into the owner's readdata, and readdatavalid pulses on the cycle after each read address is driven.
  - The non-owner's readdata holds its last value; its valid is 0.
- Address wrap: the internal increment is modulo 2**ADDR_W (1023+1 gives 0).
- Back-to-back access: a new grant can be issued in the IDLE cycle right after a burst ends, so the bus runs gap-free. Read data from the previous burst's last word and the new burst's first access overlap legally.
- Simultaneous read and write from one requester: write wins; read is ignored for that cycle (protocol error, no hang).
- Reset mid-burst aborts the burst immediately; no readdatavalid is produced for outstanding reads.

Optional Feature:
- Macro: UART_MEM_ARB_FIXED_PRIO_EN.
- Defined: requester 0 always wins ties in IDLE, and rr_last is unused.
- Undefined: round-robin as above.
- Burst hold is unchanged in both modes.

Decomposition:
- Package uart_mem_arb_pkg holds:
  - the state enum (IDLE, WR_BURST, RD_BURST);
  - the owner type (1 bit);
  - constants MAX_BURST=16 and READ_LATENCY=1.
- One natural sub-module: uart_mem_arb_rr. It is the 2-way round-robin/priority pick with the rr_last register, and it holds the macro-dependent logic.

Test Plan:
- Single write then read: m0 write addr 5, data 0xA5A5_1234, be 0xF, burst 1; then m0 read addr 5 → m0_readdatavalid exactly 1 cycle after the read is accepted, readdata 0xA5A5_1234.
- Byte lanes: write 0xFFFFFFFF to addr 7, then write 0x00000000 with be 0x2 → read returns 0xFFFF00FF.
- Contention: m0 and m1 both hold burst-1 reads for 6 cycles → grants alternate 0,1,0,1,0,1. With UART_MEM_ARB_FIXED_PRIO_EN → six consecutive m0 grants while m1 waitrequest stays 1.
- Read burst with wrap: m1 read addr 1022, burst 4 → mem_address sequence 1022, 1023, 0, 1; four consecutive m1_readdatavalid pulses; m0 request stalls until the cycle after the last address.
- Write burst with gaps: m0 write burst 3 at addr 100, deasserting write for 2 cycles after beat 1 → writes land at 100, 101, 102; m1 stays blocked until the 3rd beat is accepted.
- Reset mid-burst: assert reset_n=0 during the 2nd beat of a read burst of 8 → outputs return to reset values asynchronously; after release both requesters get service and no stray readdatavalid appears.

Source files
------------

// File: rtl/uart_mem_arb_pkg.sv
// uart_mem_arb_pkg: shared types and constants for the UART memory arbiter.
// This package holds the FSM state enum, the owner type, burst and latency
// limits, and the burst-length normalisation helper.
package uart_mem_arb_pkg;

  // Longest legal burst in words.
  localparam int MAX_BURST    = 16;
  // Cycles from a read address being clocked to its data on mem_readdata.
  localparam int READ_LATENCY = 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_BURST = 2'd1,
    RD_BURST = 2'd2
  } state_t;

  // One bit is enough to name the bus owner.
  typedef logic owner_t;

  localparam owner_t OWNER_M0 = 1'b0;
  localparam owner_t OWNER_M1 = 1'b1;

  // A burstcount of 0 is served as a single word. Anything above the
  // maximum is clipped, so a bad request cannot run away.
  function automatic int unsigned burst_beats(input int unsigned bc);
    int unsigned beats;
    if (bc == 32'd0) begin
      beats = 32'd1;
    end else if (bc > 32'(MAX_BURST)) begin
      beats = 32'(MAX_BURST);
    end else begin
      beats = bc;
    end
    return beats;
  endfunction

endpackage

// File: rtl/uart_mem_arb_rr.sv
// uart_mem_arb_rr: two-way grant pick for the UART memory arbiter.
// Build macro UART_MEM_ARB_FIXED_PRIO_EN: when it is defined, requester 0
// always wins a tie and no history is kept. When it is not defined, ties go
// to the requester that was not granted last (rr_last).
module uart_mem_arb_rr
  import uart_mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       take_i,
  output owner_t     pick_o
);

`ifdef UART_MEM_ARB_FIXED_PRIO_EN

  // Fixed priority: requester 0 wins whenever it asks.
  always_comb begin
    if (req_i[0]) begin
      pick_o = OWNER_M0;
    end else if (req_i[1]) begin
      pick_o = OWNER_M1;
    end else begin
      pick_o = OWNER_M0;
    end
  end

`else

  owner_t rr_last_q;

  // Round-robin pick: a lone requester wins, and a tie goes to the one not last granted.
  always_comb begin
    if (req_i == 2'b11) begin
      pick_o = ~rr_last_q;
    end else if (req_i[1]) begin
      pick_o = OWNER_M1;
    end else begin
      pick_o = OWNER_M0;
    end
  end

  // Remember the last owner. Reset to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last_q <= OWNER_M1;
    end else if (take_i) begin
      rr_last_q <= pick_o;
    end else begin
      rr_last_q <= rr_last_q;
    end
  end

`endif

endmodule

// File: rtl/uart_mem_arbiter.sv
// uart_mem_arbiter: two-requester arbiter and burst sequencer in front of the
// 1024x32 single-port UART memory. The memory registers its address and
// returns q one cycle later.
// Requester 0 is the UART data mover and requester 1 is the DDS/CPU side.
// A grant is held for a whole burst. Read bursts are expanded into one
// memory access per word.
// Optional build macro: UART_MEM_ARB_FIXED_PRIO_EN (requester 0 wins all ties).
module uart_mem_arbiter
  import uart_mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int BE_W    = 4,
  parameter int BURST_W = 5
) (
  input  logic               clk,
  input  logic               reset_n,
  // requester 0
  input  logic [ADDR_W-1:0]  m0_address,
  input  logic               m0_read,
  input  logic               m0_write,
  input  logic [BE_W-1:0]    m0_byteenable,
  input  logic [DATA_W-1:0]  m0_writedata,
  input  logic [BURST_W-1:0] m0_burstcount,
  output logic               m0_waitrequest,
  output logic [DATA_W-1:0]  m0_readdata,
  output logic               m0_readdatavalid,
  // requester 1
  input  logic [ADDR_W-1:0]  m1_address,
  input  logic               m1_read,
  input  logic               m1_write,
  input  logic [BE_W-1:0]    m1_byteenable,
  input  logic [DATA_W-1:0]  m1_writedata,
  input  logic [BURST_W-1:0] m1_burstcount,
  output logic               m1_waitrequest,
  output logic [DATA_W-1:0]  m1_readdata,
  output logic               m1_readdatavalid,
  // memory side
  output logic [ADDR_W-1:0]  mem_address,
  output logic [BE_W-1:0]    mem_byteenable,
  output logic               mem_chipselect,
  output logic               mem_write,
  output logic [DATA_W-1:0]  mem_writedata,
  output logic               mem_clken,
  input  logic [DATA_W-1:0]  mem_readdata
);

  state_t               state_q, state_d;
  owner_t               owner_q, owner_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [BURST_W-1:0]   remain_q, remain_d;
  logic                 run_q;

  logic [1:0]           req_s;
  owner_t               pick_s;
  logic                 take_s;

  logic [ADDR_W-1:0]    win_addr_s;
  logic [BE_W-1:0]      win_be_s;
  logic [DATA_W-1:0]    win_data_s;
  logic                 win_wr_s;
  logic [BURST_W-1:0]   win_bc_s;
  logic [BURST_W-1:0]   beats_s;

  logic                 own_write_s;
  logic [BE_W-1:0]      own_be_s;
  logic [DATA_W-1:0]    own_data_s;

  logic                 rd_issue_s;
  owner_t               rd_owner_s;
  logic [READ_LATENCY-1:0] rv_pipe_q;
  logic [READ_LATENCY-1:0] rv_own_q;
  logic                 rv_s;
  owner_t               rv_own_s;
  logic                 valid0_s, valid1_s;
  logic [DATA_W-1:0]    m0_rdata_q, m1_rdata_q;

  assign mem_clken = 1'b1;

  // run_q drops with reset and rises one clock after release, so no grant
  // can be issued while reset is low or on the release edge itself.
  assign req_s  = {(m1_read | m1_write), (m0_read | m0_write)} & {2{run_q}};
  assign take_s = (state_q == IDLE) && (req_s != 2'b00);

  uart_mem_arb_rr u_rr (
    .clk    (clk),
    .rst_n  (reset_n),
    .req_i  (req_s),
    .take_i (take_s),
    .pick_o (pick_s)
  );

  // Command fields of the requester picked in IDLE.
  assign win_addr_s = (pick_s == OWNER_M0) ? m0_address    : m1_address;
  assign win_be_s   = (pick_s == OWNER_M0) ? m0_byteenable : m1_byteenable;
  assign win_data_s = (pick_s == OWNER_M0) ? m0_writedata  : m1_writedata;
  assign win_wr_s   = (pick_s == OWNER_M0) ? m0_write      : m1_write;
  assign win_bc_s   = (pick_s == OWNER_M0) ? m0_burstcount : m1_burstcount;
  assign beats_s    = BURST_W'(burst_beats(32'(win_bc_s)));

  // Beat fields of the current burst owner.
  assign own_write_s = (owner_q == OWNER_M0) ? m0_write      : m1_write;
  assign own_be_s    = (owner_q == OWNER_M0) ? m0_byteenable : m1_byteenable;
  assign own_data_s  = (owner_q == OWNER_M0) ? m0_writedata  : m1_writedata;

  // Hold off grants until one clock after reset is released.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Burst bookkeeping: owner, next word address and words left to issue.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner_q  <= OWNER_M0;
      addr_q   <= '0;
      remain_q <= '0;
    end else begin
      owner_q  <= owner_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
    end
  end

  // Next-state and burst bookkeeping. Address increments wrap modulo 2**ADDR_W.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    case (state_q)
      IDLE: begin
        if (take_s) begin
          owner_d  = pick_s;
          addr_d   = win_addr_s + ADDR_W'(1);
          remain_d = beats_s - BURST_W'(1);
          if (beats_s == BURST_W'(1)) begin
            state_d = IDLE;
          end else if (win_wr_s) begin
            state_d = WR_BURST;
          end else begin
            state_d = RD_BURST;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WR_BURST: begin
        if (own_write_s) begin
          addr_d   = addr_q + ADDR_W'(1);
          remain_d = remain_q - BURST_W'(1);
          if (remain_q == BURST_W'(1)) begin
            state_d = IDLE;
          end else begin
            state_d = WR_BURST;
          end
        end else begin
          state_d = WR_BURST;
        end
      end
      RD_BURST: begin
        addr_d   = addr_q + ADDR_W'(1);
        remain_d = remain_q - BURST_W'(1);
        if (remain_q == BURST_W'(1)) begin
          state_d = IDLE;
        end else begin
          state_d = RD_BURST;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Memory drive, waitrequest and read-issue flags for the current state.
  always_comb begin
    mem_address    = addr_q;
    mem_byteenable = own_be_s;
    mem_writedata  = own_data_s;
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    rd_issue_s     = 1'b0;
    rd_owner_s     = owner_q;
    case (state_q)
      IDLE: begin
        if (take_s) begin
          mem_address    = win_addr_s;
          mem_byteenable = win_be_s;
          mem_writedata  = win_data_s;
          mem_chipselect = 1'b1;
          mem_write      = win_wr_s;
          rd_issue_s     = ~win_wr_s;
          rd_owner_s     = pick_s;
          if (pick_s == OWNER_M0) begin
            m0_waitrequest = 1'b0;
          end else begin
            m1_waitrequest = 1'b0;
          end
        end else begin
          mem_chipselect = 1'b0;
        end
      end
      WR_BURST: begin
        mem_chipselect = own_write_s;
        mem_write      = own_write_s;
        if (owner_q == OWNER_M0) begin
          m0_waitrequest = ~own_write_s;
        end else begin
          m1_waitrequest = ~own_write_s;
        end
      end
      RD_BURST: begin
        mem_byteenable = {BE_W{1'b1}};
        mem_chipselect = 1'b1;
        rd_issue_s     = 1'b1;
      end
      default: begin
        mem_chipselect = 1'b0;
      end
    endcase
  end

  // Delay read-issue flags by the memory latency to time readdatavalid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rv_pipe_q <= '0;
      rv_own_q  <= '0;
    end else begin
      rv_pipe_q[0] <= rd_issue_s;
      rv_own_q[0]  <= rd_owner_s;
      for (int i = 1; i < READ_LATENCY; i++) begin
        rv_pipe_q[i] <= rv_pipe_q[i-1];
        rv_own_q[i]  <= rv_own_q[i-1];
      end
    end
  end

  assign rv_s     = rv_pipe_q[READ_LATENCY-1];
  assign rv_own_s = rv_own_q[READ_LATENCY-1];
  assign valid0_s = rv_s & (rv_own_s == OWNER_M0);
  assign valid1_s = rv_s & (rv_own_s == OWNER_M1);

  // Keep each requester's last returned word so readdata holds between strobes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      m0_rdata_q <= valid0_s ? mem_readdata : m0_rdata_q;
      m1_rdata_q <= valid1_s ? mem_readdata : m1_rdata_q;
    end
  end

  assign m0_readdatavalid = valid0_s;
  assign m1_readdatavalid = valid1_s;
  assign m0_readdata      = valid0_s ? mem_readdata : m0_rdata_q;
  assign m1_readdata      = valid1_s ? mem_readdata : m1_rdata_q;

endmodule

// File: tb/tb_uart_mem_arbiter.sv
// tb_uart_mem_arbiter: scoreboard bench for uart_mem_arbiter with a behavioural
// memory (registered address, q one cycle later, byte-enabled writes).
// Expected memory accesses and read data are queued when stimulus is driven
// and checked by a negedge monitor. Build with UART_MEM_ARB_FIXED_PRIO_EN to
// check the fixed-priority variant.
module tb_uart_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [9:0]  m0_address, m1_address;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic [31:0] m0_writedata, m1_writedata;
  logic [4:0]  m0_burstcount, m1_burstcount;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [9:0]  mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [31:0] mem_writedata, mem_readdata;

  uart_mem_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
    .m0_burstcount(m0_burstcount), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
    .m1_burstcount(m1_burstcount), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata)
  );

  always #5 clk = ~clk;

  // Behavioural single-port memory.
  logic [31:0] mem [0:1023];
  logic [9:0]  mem_addr_q;
  always @(posedge clk) begin
    if (mem_chipselect && mem_clken) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) mem[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end
      mem_addr_q <= mem_address;
    end
  end
  assign mem_readdata = mem[mem_addr_q];

  // Reference model and scoreboard.
  typedef struct {
    logic [9:0]  addr;
    logic        wr;
    logic [3:0]  be;
    logic [31:0] data;
  } acc_t;

  logic [31:0] ref_mem [0:1023];
  acc_t        acc_q[$];
  logic [31:0] rd_q0[$];
  logic [31:0] rd_q1[$];
  acc_t        acc_e;
  logic [31:0] rd_e;
  int          n_total = 0;
  int          n_bad   = 0;
  int          last_owner;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic push_acc(input logic [9:0] a, input logic wr, input logic [3:0] be, input logic [31:0] d);
    acc_t e;
    e.addr = a; e.wr = wr; e.be = be; e.data = d;
    acc_q.push_back(e);
    if (wr) ref_mem[a] = merge(ref_mem[a], d, be);
  endtask

  task automatic push_rd(input int id, input logic [9:0] a);
    if (id == 0) rd_q0.push_back(ref_mem[a]);
    else         rd_q1.push_back(ref_mem[a]);
  endtask

  task automatic drive(input int id, input logic rd, input logic wr, input logic [9:0] a,
                       input logic [3:0] be, input logic [31:0] d, input logic [4:0] bc);
    if (id == 0) begin
      m0_read = rd; m0_write = wr; m0_address = a; m0_byteenable = be;
      m0_writedata = d; m0_burstcount = bc;
    end else begin
      m1_read = rd; m1_write = wr; m1_address = a; m1_byteenable = be;
      m1_writedata = d; m1_burstcount = bc;
    end
  endtask

  function automatic logic wreq(input int id);
    return (id == 0) ? m0_waitrequest : m1_waitrequest;
  endfunction

  task automatic sync();
    @(posedge clk); #1;
  endtask

  // Single-word access. The caller must start at posedge+1; the task returns at posedge+1.
  task automatic single(input int id, input logic wr, input logic [9:0] a,
                        input logic [3:0] be, input logic [31:0] d);
    int k;
    push_acc(a, wr, be, d);
    if (!wr) push_rd(id, a);
    drive(id, !wr, wr, a, be, d, 5'd1);
    k = 0;
    @(negedge clk);
    while (wreq(id) !== 1'b0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check_eq("single_grant", 32'(wreq(id)), 32'd0);
    sync();
    drive(id, 1'b0, 1'b0, 10'd0, 4'h0, 32'd0, 5'd1);
    last_owner = id;
  endtask

  // Monitor: every memory access and read strobe must match the scoreboard.
  always @(negedge clk) begin
    if (mem_chipselect === 1'b1) begin
      check_eq("acc_expected", 32'(acc_q.size() > 0), 32'd1);
      if (acc_q.size() > 0) begin
        acc_e = acc_q.pop_front();
        check_eq("acc_addr", 32'(mem_address), 32'(acc_e.addr));
        check_eq("acc_wr", 32'(mem_write), 32'(acc_e.wr));
        if (acc_e.wr) begin
          check_eq("acc_wdata", mem_writedata, acc_e.data);
          check_eq("acc_be", 32'(mem_byteenable), 32'(acc_e.be));
        end
      end
    end
    if (m0_readdatavalid === 1'b1) begin
      check_eq("m0_rdv_expected", 32'(rd_q0.size() > 0), 32'd1);
      if (rd_q0.size() > 0) begin
        rd_e = rd_q0.pop_front();
        check_eq("m0_rdata", m0_readdata, rd_e);
      end
    end
    if (m1_readdatavalid === 1'b1) begin
      check_eq("m1_rdv_expected", 32'(rd_q1.size() > 0), 32'd1);
      if (rd_q1.size() > 0) begin
        rd_e = rd_q1.pop_front();
        check_eq("m1_rdata", m1_readdata, rd_e);
      end
    end
  end

  initial begin
    int w;
    logic [9:0] a;
    reset_n = 1'b0;
    last_owner = 1;
    drive(0, 1'b0, 1'b0, 10'd0, 4'h0, 32'd0, 5'd1);
    drive(1, 1'b0, 1'b0, 10'd0, 4'h0, 32'd0, 5'd1);
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_m0_wait", 32'(m0_waitrequest), 32'd1);
    check_eq("rst_m1_wait", 32'(m1_waitrequest), 32'd1);
    check_eq("rst_cs", 32'(mem_chipselect), 32'd0);
    check_eq("rst_wr", 32'(mem_write), 32'd0);
    check_eq("rst_m0_rdv", 32'(m0_readdatavalid), 32'd0);
    check_eq("rst_m1_rdv", 32'(m1_readdatavalid), 32'd0);
    check_eq("clken", 32'(mem_clken), 32'd1);
    reset_n = 1'b1;
    sync(); sync();

    // Single write then read, with the one-cycle readdatavalid latency.
    single(0, 1'b1, 10'd5, 4'hF, 32'hA5A5_1234);
    single(0, 1'b0, 10'd5, 4'hF, 32'd0);
    @(negedge clk);
    check_eq("t1_rdv_lat1", 32'(m0_readdatavalid), 32'd1);
    @(negedge clk);
    check_eq("t1_rdv_single", 32'(m0_readdatavalid), 32'd0);
    sync();
    // The non-owner's readdata must hold while the other requester gets data.
    single(1, 1'b1, 10'd9, 4'hF, 32'h1111_2222);
    single(1, 1'b0, 10'd9, 4'hF, 32'd0);
    @(negedge clk);
    check_eq("t1_m0_hold", m0_readdata, ref_mem[5]);
    check_eq("t1_m0_rdv_off", 32'(m0_readdatavalid), 32'd0);
    sync();

    // Byte lanes.
    single(0, 1'b1, 10'd7, 4'hF, 32'hFFFF_FFFF);
    single(0, 1'b1, 10'd7, 4'h2, 32'h0000_0000);
    single(0, 1'b0, 10'd7, 4'hF, 32'd0);
    single(1, 1'b0, 10'd7, 4'hF, 32'd0);

    // Contention: both requesters hold burst-1 reads for six cycles.
    drive(0, 1'b1, 1'b0, 10'd5, 4'hF, 32'd0, 5'd1);
    drive(1, 1'b1, 1'b0, 10'd7, 4'hF, 32'd0, 5'd1);
    for (int i = 0; i < 6; i++) begin
`ifdef UART_MEM_ARB_FIXED_PRIO_EN
      w = 0;
`else
      w = (last_owner == 0) ? 1 : 0;
`endif
      a = (w == 0) ? 10'd5 : 10'd7;
      push_acc(a, 1'b0, 4'hF, 32'd0);
      push_rd(w, a);
      @(negedge clk);
      check_eq("cont_m0_wait", 32'(m0_waitrequest), 32'(w != 0));
      check_eq("cont_m1_wait", 32'(m1_waitrequest), 32'(w != 1));
      last_owner = w;
      sync();
    end
    drive(0, 1'b0, 1'b0, 10'd0, 4'h0, 32'd0, 5'd1);
    drive(1, 1'b0, 1'b0, 10'd0, 4'h0, 32'd0, 5'd1);
    sync(); sync();

    // Read burst across the top of the address space.
    single(0, 1'b1, 10'd1022, 4'hF, 32'hC0DE_03FE);
    single(0, 1'b1, 10'd1023, 4'hF, 32'hC0DE_03FF);
    single(0, 1'b1, 10'd0,    4'hF, 32'hC0DE_0000);
    single(0, 1'b1, 10'd1,    4'hF, 32'hC0DE_0001);
    push_acc(10'd1022, 1'b0, 4'hF, 32'd0); push_rd(1, 10'd1022);
    push_acc(10'd1023, 1'b0, 4'hF, 32'd0); push_rd(1, 10'd1023);
    push_acc(10'd0,    1'b0, 4'hF, 32'd0); push_rd(1, 10'd0);
    push_acc(10'd1,    1'b0, 4'hF, 32'd0); push_rd(1, 10'd1);
    push_acc(10'd5,    1'b0, 4'hF, 32'd0); push_rd(0, 10'd5);
    drive(1, 1'b1, 1'b0, 10'd1022, 4'hF, 32'd0, 5'd4);
    @(negedge clk);
    check_eq("wrap_m1_grant", 32'(m1_waitrequest), 32'd0);
    sync();
    drive(1, 1'b0, 1'b0, 10'd0, 4'h0, 32'd0, 5'd1);
    drive(0, 1'b1, 1'b0, 10'd5, 4'hF, 32'd0, 5'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("wrap_m0_stall", 32'(m0_waitrequest), 32'd1);
      check_eq("wrap_m1_rdv", 32'(m1_readdatavalid), 32'd1);
      sync();
    end
    @(negedge clk);
    check_eq("wrap_m0_grant", 32'(m0_waitrequest), 32'd0);
    check_eq("wrap_m1_rdv4", 32'(m1_readdatavalid), 32'd1);
    sync();
    drive(0, 1'b0, 1'b0, 10'd0, 4'h0, 32'd0, 5'd1);
    last_owner = 0;
    @(negedge clk);
    check_eq("wrap_m1_rdv_end", 32'(m1_readdatavalid), 32'd0);
    check_eq("wrap_m0_rdv", 32'(m0_readdatavalid), 32'd1);
    sync();

    // Write burst with idle gaps while m1 waits.
    push_acc(10'd100, 1'b1, 4'hF, 32'h0000_1064);
    push_acc(10'd101, 1'b1, 4'hF, 32'h0000_1065);
    push_acc(10'd102, 1'b1, 4'hF, 32'h0000_1066);
    push_acc(10'd100, 1'b0, 4'hF, 32'd0); push_rd(1, 10'd100);
    push_acc(10'd101, 1'b0, 4'hF, 32'd0); push_rd(1, 10'd101);
    push_acc(10'd102, 1'b0, 4'hF, 32'd0); push_rd(1, 10'd102);
    drive(0, 1'b0, 1'b1, 10'd100, 4'hF, 32'h0000_1064, 5'd3);
    @(negedge clk);
    check_eq("wb_beat1", 32'(m0_waitrequest), 32'd0);
    sync();
    drive(0, 1'b0, 1'b0, 10'd500, 4'hF, 32'hBAD0_BAD0, 5'd3);
    drive(1, 1'b1, 1'b0, 10'd100, 4'hF, 32'd0, 5'd3);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check_eq("wb_gap_m1_wait", 32'(m1_waitrequest), 32'd1);
      check_eq("wb_gap_cs", 32'(mem_chipselect), 32'd0);
      sync();
    end
    drive(0, 1'b0, 1'b1, 10'd500, 4'hF, 32'h0000_1065, 5'd3);
    @(negedge clk);
    check_eq("wb_beat2", 32'(m0_waitrequest), 32'd0);
    check_eq("wb_b2_m1_wait", 32'(m1_waitrequest), 32'd1);
    sync();
    drive(0, 1'b0, 1'b1, 10'd501, 4'hF, 32'h0000_1066, 5'd3);
    @(negedge clk);
    check_eq("wb_beat3", 32'(m0_waitrequest), 32'd0);
    check_eq("wb_b3_m1_wait", 32'(m1_waitrequest), 32'd1);
    sync();
    drive(0, 1'b0, 1'b0, 10'd0, 4'h0, 32'd0, 5'd1);
    @(negedge clk);
    check_eq("wb_m1_grant", 32'(m1_waitrequest), 32'd0);
    sync();
    drive(1, 1'b0, 1'b0, 10'd0, 4'h0, 32'd0, 5'd1);
    last_owner = 1;
    repeat (5) sync();

    // Reset in the middle of an 8-word read burst.
    push_acc(10'd200, 1'b0, 4'hF, 32'd0);
    drive(0, 1'b1, 1'b0, 10'd200, 4'hF, 32'd0, 5'd8);
    @(negedge clk);
    check_eq("rb_grant", 32'(m0_waitrequest), 32'd0);
    sync();
    drive(0, 1'b0, 1'b0, 10'd0, 4'h0, 32'd0, 5'd1);
    #1;
    check_eq("rb_beat2_addr", 32'(mem_address), 32'd201);
    check_eq("rb_beat2_rdv", 32'(m0_readdatavalid), 32'd1);
    #1;
    reset_n = 1'b0;
    drive(0, 1'b1, 1'b0, 10'd5, 4'hF, 32'd0, 5'd1);
    drive(1, 1'b1, 1'b0, 10'd7, 4'hF, 32'd0, 5'd1);
    #1;
    check_eq("rb_m0_wait", 32'(m0_waitrequest), 32'd1);
    check_eq("rb_m1_wait", 32'(m1_waitrequest), 32'd1);
    check_eq("rb_cs", 32'(mem_chipselect), 32'd0);
    check_eq("rb_wr", 32'(mem_write), 32'd0);
    check_eq("rb_rdv", 32'(m0_readdatavalid), 32'd0);
    repeat (2) sync();
    drive(0, 1'b0, 1'b0, 10'd0, 4'h0, 32'd0, 5'd1);
    drive(1, 1'b0, 1'b0, 10'd0, 4'h0, 32'd0, 5'd1);
    sync();
    reset_n = 1'b1;
    last_owner = 1;
    sync(); sync();
    single(0, 1'b0, 10'd5, 4'hF, 32'd0);
    single(1, 1'b0, 10'd9, 4'hF, 32'd0);
    repeat (5) sync();

    check_eq("acc_q_left", 32'(acc_q.size()), 32'd0);
    check_eq("rd_q0_left", 32'(rd_q0.size()), 32'd0);
    check_eq("rd_q1_left", 32'(rd_q1.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
